// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: operand-forward selects,
// load-use and taken-branch stall/flush, memory-wait freeze and event counters.
module hazard_fwd_ctrl #(
   parameter int BR_FLUSH_CYCLES = 1,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic             RegWriteE,
   input  logic             ResultSrcE,
   input  logic             PCSrcE,
   input  logic             mem_stall_i,
   input  logic             clr_cnt_i,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             busy_o,
   output logic [CNT_W-1:0] lu_stall_cnt,
   output logic [CNT_W-1:0] br_flush_cnt
);

   typedef enum logic {RUN, BR_FLUSH} state_t;

   localparam logic [1:0] BR_LOAD = 2'(BR_FLUSH_CYCLES);

   state_t     state, state_nxt;
   logic [1:0] fcnt, fcnt_nxt;
   logic [4:0] rd_m, rd_w;
   logic       we_m, we_w;
   logic       lu, lu_evt, br_evt;

   // Destination shadow of M/W; a flushed E slot enters M as a non-writer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_m <= '0;
         we_m <= 1'b0;
         rd_w <= '0;
         we_w <= 1'b0;
      end else if (!mem_stall_i) begin
         rd_m <= RdE;
         we_m <= RegWriteE & ~FlushE;
         rd_w <= rd_m;
         we_w <= we_m;
      end
   end

   always_comb begin
      ForwardAE = 2'b00;
      if (we_m && rd_m != 5'd0 && rd_m == Rs1E)      ForwardAE = 2'b01;
      else if (we_w && rd_w != 5'd0 && rd_w == Rs1E) ForwardAE = 2'b10;
      ForwardBE = 2'b00;
      if (we_m && rd_m != 5'd0 && rd_m == Rs2E)      ForwardBE = 2'b01;
      else if (we_w && rd_w != 5'd0 && rd_w == Rs2E) ForwardBE = 2'b10;
   end

   assign lu = ResultSrcE && RegWriteE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         fcnt  <= '0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      if (!mem_stall_i) begin
         case (state)
            RUN: begin
               if (PCSrcE && BR_FLUSH_CYCLES > 0) begin
                  state_nxt = BR_FLUSH;
                  fcnt_nxt  = BR_LOAD;
               end
            end
            BR_FLUSH: begin
               if (PCSrcE) begin
                  fcnt_nxt = BR_LOAD;
               end else begin
                  fcnt_nxt = fcnt - 2'd1;
                  if (fcnt == 2'd1) state_nxt = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // Memory wait dominates; a pending or new branch flush beats load-use.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      lu_evt = 1'b0;
      br_evt = 1'b0;
      busy_o = (state == BR_FLUSH);
      if (mem_stall_i) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
      end else if (state == BR_FLUSH || PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         br_evt = PCSrcE;
      end else if (lu) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
         lu_evt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lu_stall_cnt <= '0;
         br_flush_cnt <= '0;
      end else if (clr_cnt_i) begin
         lu_stall_cnt <= '0;
         br_flush_cnt <= '0;
      end else begin
         if (lu_evt && lu_stall_cnt != '1) lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
         if (br_evt && br_flush_cnt != '1) br_flush_cnt <= br_flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: two instances (short/long branch flush, narrow/wide
// counters) driven in lockstep and compared every cycle against a behavioural model.
module tb_hazard_fwd_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
   logic       RegWriteE, ResultSrcE, PCSrcE, mem_stall_i, clr_cnt_i;

   logic [1:0] fwa [2];
   logic [1:0] fwb [2];
   logic stl_f [2], stl_d [2], stl_e [2], stl_m [2], fl_d [2], fl_e [2], bsy [2];
   logic [3:0]  lu0, br0;
   logic [15:0] lu1, br1;

   hazard_fwd_ctrl #(.BR_FLUSH_CYCLES(1), .CNT_W(4)) u0 (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .mem_stall_i(mem_stall_i), .clr_cnt_i(clr_cnt_i),
      .ForwardAE(fwa[0]), .ForwardBE(fwb[0]), .StallF(stl_f[0]), .StallD(stl_d[0]),
      .StallE(stl_e[0]), .StallM(stl_m[0]), .FlushD(fl_d[0]), .FlushE(fl_e[0]),
      .busy_o(bsy[0]), .lu_stall_cnt(lu0), .br_flush_cnt(br0));

   hazard_fwd_ctrl #(.BR_FLUSH_CYCLES(3), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .mem_stall_i(mem_stall_i), .clr_cnt_i(clr_cnt_i),
      .ForwardAE(fwa[1]), .ForwardBE(fwb[1]), .StallF(stl_f[1]), .StallD(stl_d[1]),
      .StallE(stl_e[1]), .StallM(stl_m[1]), .FlushD(fl_d[1]), .FlushE(fl_e[1]),
      .busy_o(bsy[1]), .lu_stall_cnt(lu1), .br_flush_cnt(br1));

   int vectors = 0;
   int miscomp = 0;

   // Model: per instance, M/W writer history, flush cycles still owed, counter values.
   int BRC  [2] = '{1, 3};
   int MAXC [2] = '{15, 65535};
   int m_rd [2][2];
   int m_we [2][2];
   int left [2];
   int luc  [2];
   int brc  [2];
   logic [10:0] ev [2];
   bit e_fe [2], e_lu [2], e_br [2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int s = 0; s < 2; s++) begin
            m_rd[k][s] = 0;
            m_we[k][s] = 0;
         end
         left[k] = 0;
         luc[k]  = 0;
         brc[k]  = 0;
      end
   endtask

   function automatic logic [1:0] mfwd(int k, logic [4:0] rs);
      if (m_we[k][0] != 0 && m_rd[k][0] != 0 && m_rd[k][0] == int'(rs)) return 2'b01;
      if (m_we[k][1] != 0 && m_rd[k][1] != 0 && m_rd[k][1] == int'(rs)) return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_eval();
      for (int k = 0; k < 2; k++) begin
         bit lu, sf, sd, sem, fdd, fee;
         lu = ResultSrcE && RegWriteE && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
         sf = 0; sd = 0; sem = 0; fdd = 0; fee = 0;
         e_lu[k] = 0; e_br[k] = 0;
         if (mem_stall_i) begin
            sf = 1; sd = 1; sem = 1;
         end else if (PCSrcE || left[k] > 0) begin
            fdd = 1; fee = 1; e_br[k] = PCSrcE;
         end else if (lu) begin
            sf = 1; sd = 1; fee = 1; e_lu[k] = 1;
         end
         e_fe[k] = fee;
         ev[k] = {mfwd(k, Rs1E), mfwd(k, Rs2E), sf, sd, sem, sem, fdd, fee, left[k] > 0};
      end
   endtask

   task automatic model_update();
      if (rst) begin
         model_reset();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         if (!mem_stall_i) begin
            m_rd[k][1] = m_rd[k][0];
            m_we[k][1] = m_we[k][0];
            m_rd[k][0] = int'(RdE);
            m_we[k][0] = (RegWriteE && !e_fe[k]) ? 1 : 0;
            if (PCSrcE) left[k] = BRC[k];
            else if (left[k] > 0) left[k] = left[k] - 1;
         end
         if (clr_cnt_i) begin
            luc[k] = 0;
            brc[k] = 0;
         end else begin
            if (e_lu[k] && luc[k] < MAXC[k]) luc[k]++;
            if (e_br[k] && brc[k] < MAXC[k]) brc[k]++;
         end
      end
   endtask

   function automatic logic [10:0] outv(int k);
      return {fwa[k], fwb[k], stl_f[k], stl_d[k], stl_e[k], stl_m[k], fl_d[k], fl_e[k], bsy[k]};
   endfunction

   task automatic chk(string nm, int act, int exp);
      if (act != exp) begin
         miscomp++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_eval();
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (outv(k) !== ev[k]) begin
            miscomp++;
            $display("FAIL outputs dut%0d: got %h want %h (t=%0t)", k, outv(k), ev[k], $time);
         end
      end
      chk("lu_cnt dut0", int'(lu0), luc[0]);
      chk("br_cnt dut0", int'(br0), brc[0]);
      chk("lu_cnt dut1", int'(lu1), luc[1]);
      chk("br_cnt dut1", int'(br1), brc[1]);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
      RegWriteE = 0; ResultSrcE = 0; PCSrcE = 0; mem_stall_i = 0; clr_cnt_i = 0;
   endtask

   task automatic set_lu(logic [4:0] r);
      RdE = r; ResultSrcE = 1; RegWriteE = 1; Rs1D = r;
   endtask

   initial begin
      idle();
      model_reset();
      #2;
      chk("reset outs dut0", int'(outv(0)), 0);
      chk("reset outs dut1", int'(outv(1)), 0);
      chk("reset cnts", int'({lu0, br0, lu1, br1}), 0);
      @(posedge clk); #1;
      rst = 0;

      // forwarding priority
      idle(); RdE = 5; RegWriteE = 1;
      cycle(); cycle();
      idle(); Rs1E = 5; #1;
      chk("fwdA M over W dut0", int'(fwa[0]), 1);
      chk("fwdA M over W dut1", int'(fwa[1]), 1);
      cycle();
      idle(); Rs2E = 5; #1;
      chk("fwdB from W", int'(fwb[0]), 2);
      cycle();
      idle(); RdE = 0; RegWriteE = 1; cycle();
      idle(); #1;
      chk("fwd x0", int'(fwa[0]), 0);
      cycle();

      // load-use
      idle(); clr_cnt_i = 1; cycle();
      idle(); RdE = 7; ResultSrcE = 1; RegWriteE = 1; Rs2D = 7; #1;
      chk("lu stallF/D flushE", int'({stl_f[0], stl_d[0], fl_e[0], stl_e[0]}), 4'b1110);
      cycle();
      idle(); Rs1E = 7; #1;
      chk("lu bubble no fwd", int'(fwa[0]), 0);
      chk("lu cnt one", int'(lu0), 1);
      chk("lu stall one cycle", int'(stl_d[0]), 0);
      cycle();

      // taken branch with simultaneous load-use
      idle(); clr_cnt_i = 1; cycle();
      idle(); PCSrcE = 1; set_lu(7); #1;
      chk("br c1 flush no stall", int'({fl_d[0], fl_e[0], stl_d[0], bsy[0]}), 4'b1100);
      cycle();
      idle(); #1;
      chk("br c2 flush busy", int'({fl_d[0], fl_e[0], bsy[0]}), 3'b111);
      cycle();
      idle(); #1;
      chk("br c3 idle", int'({fl_d[0], fl_e[0], bsy[0]}), 0);
      chk("br cnt", int'(br0), 1);
      chk("br long still busy", int'(bsy[1]), 1);
      cycle(); cycle(); cycle();

      // memory wait inside BR_FLUSH
      idle(); PCSrcE = 1; cycle();
      idle(); mem_stall_i = 1; #1;
      chk("ms stalls", int'({stl_f[0], stl_d[0], stl_e[0], stl_m[0], fl_d[0], fl_e[0], bsy[0]}), 7'b1111001);
      cycle(); cycle(); cycle();
      idle(); #1;
      chk("ms resume flush", int'({fl_d[0], fl_e[0], bsy[0]}), 3'b111);
      cycle();
      idle(); #1;
      chk("ms flush done", int'({fl_d[0], fl_e[0], bsy[0]}), 0);
      cycle(); cycle(); cycle();

      // counter saturation and clear priority
      idle(); clr_cnt_i = 1; cycle();
      idle(); set_lu(9);
      repeat (20) cycle();
      idle(); #1;
      chk("lu sat cnt4", int'(lu0), 15);
      chk("lu cnt16", int'(lu1), 20);
      set_lu(9); clr_cnt_i = 1; cycle();
      idle(); #1;
      chk("clr beats inc", int'(lu0), 0);
      cycle();

      // async reset mid-flush
      idle(); PCSrcE = 1; cycle();
      idle(); #1;
      chk("pre-rst busy", int'({bsy[0], bsy[1]}), 2'b11);
      rst = 1; #1;
      chk("async rst drop", int'({bsy[0], fl_d[0], fl_e[0], bsy[1], fl_d[1], fl_e[1]}), 0);
      model_reset();
      cycle();
      rst = 0;
      idle(); Rs1E = 5; Rs2E = 5; #1;
      chk("fwd after rst", int'({fwa[0], fwb[0], fwa[1], fwb[1]}), 0);
      cycle();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         Rs1D = 5'($urandom_range(0, 7));
         Rs2D = 5'($urandom_range(0, 7));
         Rs1E = 5'($urandom_range(0, 7));
         Rs2E = 5'($urandom_range(0, 7));
         RdE  = 5'($urandom_range(0, 7));
         RegWriteE   = ($urandom % 4) != 0;
         ResultSrcE  = ($urandom % 3) == 0;
         PCSrcE      = ($urandom % 8) == 0;
         mem_stall_i = ($urandom % 8) == 0;
         clr_cnt_i   = ($urandom % 64) == 0;
         rst         = ($urandom % 400) == 0;
         if (rst) model_reset();
         cycle();
      end
      rst = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage core.
- Sits beside the decode/execute/memory stages and drives the execute-stage operand-forwarding selects.
- Generates the fetch/decode stall and the decode/execute flush controls for load-use hazards, taken branches and external memory wait states.
- Keeps its own M/W-stage destination shadow (scoreboard), a branch-flush FSM and hazard event counters.

Parameters:
- BR_FLUSH_CYCLES, 1: extra cycles of FlushD/FlushE after the cycle PCSrcE is seen; range 0..3. Needed because PCSrcE is registered one stage late.
- CNT_W, 16: width of the saturating event counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- Rs1D  in  5  decode-stage source register 1
- Rs2D  in  5  decode-stage source register 2
- Rs1E  in  5  execute-stage source register 1
- Rs2E  in  5  execute-stage source register 2
- RdE  in  5  execute-stage destination
- RegWriteE  in  1  execute-stage write enable
- ResultSrcE  in  1  1 = execute-stage instruction is a load
- PCSrcE  in  1  registered branch-taken from execute
- mem_stall_i  in  1  data memory not ready; freeze the whole pipeline
- clr_cnt_i  in  1  synchronous clear of the counters
- ForwardAE  out  2  ALU A select: 00 reg, 01 M ALU result, 10 W result
- ForwardBE  out  2  ALU B select, same encoding
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID
- StallE  out  1  hold ID/EX
- StallM  out  1  hold EX/MEM
- FlushD  out  1  bubble IF/ID
- FlushE  out  1  bubble ID/EX
- busy_o  out  1  FSM not in RUN
- lu_stall_cnt  out  CNT_W  load-use stall cycles
- br_flush_cnt  out  CNT_W  taken-branch events

Behaviour:
- Reset (async):
  - Shadows RdM, RegWriteM, RdW, RegWriteW are all 0; state is RUN; flush counter is 0; both event counters are 0.
  - Therefore ForwardAE = ForwardBE = 00, all Stall/Flush outputs are 0 and busy_o = 0.
- Shadow scoreboard, updated on each clk edge unless mem_stall_i:
  - M shadow <= {RdE, RegWriteE & ~FlushE_int}.
  - W shadow <= M shadow.
  - FlushE_int is this cycle's FlushE. A bubbled instruction must never be forwarded from.
  - When mem_stall_i = 1, both shadows hold.
- Forwarding (combinational from the shadows), shown for A; B is the same using Rs2E:
  - 01 if RegWriteM && RdM != 0 && RdM == Rs1E.
  - Else 10 if RegWriteW && RdW != 0 && RdW == Rs1E.
  - Else 00.
  - M has priority over W. x0 is never forwarded.
- Load-use detect: lu = ResultSrcE && RegWriteE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
- FSM state RUN:
  - PCSrcE = 1: FlushD = FlushE = 1. If BR_FLUSH_CYCLES > 0, load the flush counter with BR_FLUSH_CYCLES and go to BR_FLUSH. Increment br_flush_cnt. lu is ignored this cycle (the branch wins).
  - Otherwise, lu = 1: StallF = StallD = 1 and FlushE = 1 for exactly that cycle. Increment lu_stall_cnt. Stay in RUN; re-evaluate lu next cycle, which clears once the bubble enters E.
- FSM state BR_FLUSH:
  - FlushD = FlushE = 1; decrement the counter; return to RUN when it reaches 1.
  - lu is suppressed.
  - A new PCSrcE in this state reloads the counter and increments br_flush_cnt.
  - busy_o = 1.
- mem_stall_i = 1 (highest priority):
  - StallF = StallD = StallE = StallM = 1; FlushD = FlushE = 0.
  - FSM, flush counter and shadows freeze; no counter increments.
  - PCSrcE is ignored and must be re-presented by the frozen execute stage.
- StallE and StallM are asserted only by mem_stall_i.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_cnt_i zeroes them on the next edge and takes priority over an increment in the same cycle.
- Reset mid-flush: returns to RUN immediately and all outputs deassert asynchronously.

Test Plan:
- Forwarding priority: E writes x5 (RegWriteE=1), then E writes x5 again, then Rs1E = 5 -> ForwardAE = 01 (M wins over W). One cycle later, with no new x5 writer, Rs2E = 5 -> ForwardBE = 10. Rd = 0 with Rs1E = 0 -> 00.
- Load-use: RdE = 7, ResultSrcE = 1, RegWriteE = 1, Rs2D = 7 -> exactly one cycle of StallF = StallD = FlushE = 1; lu_stall_cnt = 1. The bubbled slot never produces Forward = 01 for x7 in the following cycle.
- Branch: PCSrcE pulse with BR_FLUSH_CYCLES = 1 -> FlushD/FlushE high for 2 consecutive cycles; busy_o high in the 2nd cycle only; br_flush_cnt = 1. A simultaneous lu in the first cycle -> no StallD.
- Memory wait: mem_stall_i high for 3 cycles during BR_FLUSH -> all four Stall outputs = 1, Flush = 0, and the FSM resumes its remaining flush cycle after release. Shadows are unchanged, so the Forward selects are identical before and after.
- Counter saturation/clear: CNT_W = 4, 20 load-use events -> lu_stall_cnt = 15. clr_cnt_i asserted together with an event -> 0.
- Async reset asserted mid-BR_FLUSH between clock edges -> busy_o, FlushD and FlushE drop immediately, and Forward = 00 after reset.
